// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider.
//   - state encodings for the divider FSM
//   - start/stop and ready/not-ready levels
//   - word and double-word widths, zero constants
//   - EX-side aluop codes that launch a divide, plus a decode helper
package div_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [DATA_W-1:0]   ZERO_WORD        = '0;
    localparam logic [2*DATA_W-1:0] ZERO_DOUBLE_WORD = '0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // EX stage uses this to decide when to raise start_i.
    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring integer divider (signed and unsigned).
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   signed_div_i  1 = signed divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high until the result is consumed
//   annul_i       abort an in-flight divide
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
//
// state       | meaning
// DIV_FREE    | idle, waiting for start_i
// DIV_BY_ZERO | divisor was zero, result will be 0
// DIV_ON      | iterating, one quotient bit per cycle
// DIV_END     | result held until start_i drops
module div
    import div_pkg::*;
#(
    parameter int DATA_W = div_pkg::DATA_W,
    parameter int CNT_W  = div_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    div_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;     // holds the dividend, shifted out as quotient bits shift in
    logic [DATA_W-1:0] r_dvsr;
    logic              r_sign1;
    logic              r_sign2;
    logic              r_signed;

    logic [DATA_W-1:0] w_abs1;
    logic [DATA_W-1:0] w_abs2;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_quo_fix;
    logic [DATA_W-1:0] w_rem_fix;
    logic              w_abort;

    assign w_abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (ZERO_WORD - opdata1_i) : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (ZERO_WORD - opdata2_i) : opdata2_i;

    // One restoring step: bring the next dividend bit into the partial
    // remainder and trial-subtract. The extra top bit is the borrow.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};

    assign w_quo_fix = (r_signed && (r_sign1 ^ r_sign2)) ? (ZERO_WORD - r_quo) : r_quo;
    assign w_rem_fix = (r_signed && r_sign1)             ? (ZERO_WORD - r_rem) : r_rem;

    // Dropping start mid-operation is treated exactly like a flush.
    assign w_abort = annul_i || (start_i == DIV_STOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= DIV_FREE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_signed <= 1'b0;
            result_o <= ZERO_DOUBLE_WORD;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    result_o <= ZERO_DOUBLE_WORD;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    r_cnt    <= '0;
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == ZERO_WORD) begin
                            r_state <= DIV_BY_ZERO;
                        end else begin
                            r_state  <= DIV_ON;
                            r_rem    <= '0;
                            r_quo    <= w_abs1;
                            r_dvsr   <= w_abs2;
                            r_sign1  <= opdata1_i[DATA_W-1];
                            r_sign2  <= opdata2_i[DATA_W-1];
                            r_signed <= signed_div_i;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    result_o <= ZERO_DOUBLE_WORD;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    r_state  <= w_abort ? DIV_FREE : DIV_END;
                end
                DIV_ON: begin
                    if (w_abort) begin
                        r_state  <= DIV_FREE;
                        r_cnt    <= '0;
                        result_o <= ZERO_DOUBLE_WORD;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end else if (r_cnt == CNT_W'(DATA_W)) begin
                        r_state  <= DIV_END;
                        r_cnt    <= '0;
                        result_o <= {w_rem_fix, w_quo_fix};
                        ready_o  <= DIV_RESULT_READY;
                    end else begin
                        r_rem <= w_diff[DATA_W] ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], ~w_diff[DATA_W]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        r_state  <= DIV_FREE;
                        result_o <= ZERO_DOUBLE_WORD;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end else begin
                        ready_o  <= DIV_RESULT_READY;
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [63:0] last_res;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required < 500000)", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sd;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sd = {{32{b[31]}}, b};
            q  = 32'(sa / sd);
            r  = 32'(sa % sd);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Launch one divide, wait for ready, compare against the scoreboard,
    // hold start for a few cycles (pulsing annul, which must be ignored),
    // then release and check the output clears.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   lat;
        e.res = model(s, a, b);
        e.lat = (b == 32'd0) ? 2 : 33;
        sb.push_back(e);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        signed_div_i = 1'($urandom);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = n;
                break;
            end
        end
        e = sb.pop_front();
        chk("latency", 64'(lat), 64'(e.lat));
        chk("result", result_o, e.res);
        last_res = result_o;
        annul_i = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_ready", 64'(ready_o), 64'd1);
            chk("hold_result", result_o, e.res);
        end
        annul_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_ready", 64'(ready_o), 64'd0);
        chk("drop_result", result_o, 64'd0);
    endtask

    // Start an operation and abort it after n DivOn edges, either with
    // annul or by dropping start; ready must then stay low.
    task automatic abort_div(input logic [31:0] a, input logic [31:0] b, input int n, input logic use_annul);
        int seen;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        if (use_annul) annul_i = 1'b1;
        else           start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        chk(use_annul ? "annul_ready_low" : "dropstart_ready_low", 64'(seen), 64'd0);
    endtask

    initial begin
        int lat;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        last_res     = '0;
        #1;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        #20;
        @(negedge clk);
        rst = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, 3);
        chk("u100_7", last_res, 64'h00000002_0000000E);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1);
        chk("s-7_2", last_res, 64'hFFFFFFFF_FFFFFFFD);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1);
        chk("s7_-2", last_res, 64'h00000001_FFFFFFFD);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("s_overflow", last_res, 64'h00000000_80000000);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 0);
        run_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_div(1'b0, 32'd3, 32'd10, 0);
        run_div(1'b0, 32'd12345, 32'd0, 2);
        run_div(1'b1, 32'h80000000, 32'd0, 0);

        abort_div(32'd1000, 32'd3, 10, 1'b1);
        run_div(1'b0, 32'd50, 32'd5, 0);
        chk("u50_5_after_annul", last_res, 64'h00000000_0000000A);
        abort_div(32'd1000, 32'd3, 5, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i < 3) ? $urandom : 32'($urandom_range(1, 300));
            if (b == 32'd0) b = 32'd1;
            run_div(1'(i % 2), a, b, 0);
        end

        // Reset mid-DivOn, asserted between clock edges.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_midop_ready", 64'(ready_o), 64'd0);
        chk("rst_midop_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Reset while a result is being held must clear it immediately.
        @(negedge clk);
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = 1;
                break;
            end
        end
        chk("pre_rst_ready", 64'(lat), 64'd1);
        chk("pre_rst_result", result_o, model(1'b0, 32'd1000, 32'd7));
        #2;
        rst = 1'b0;
        #1;
        chk("rst_end_ready", 64'(ready_o), 64'd0);
        chk("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_div(1'b0, 32'd9, 32'd4, 0);
        chk("u9_4_after_rst", last_res, 64'h00000001_00000002);

        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
